// File: rtl/winograd_pkg.sv
// Shared constants, FSM state type and MSB-first tile indexing helpers
// for the Winograd F(2x2,3x3) output transform.
package winograd_pkg;

  localparam int unsigned TILE_N = 16;
  localparam int unsigned OUT_N  = 4;
  localparam int unsigned ELEM_W = 16;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned OUT_W  = 26;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_XF1,
    ST_XF2,
    ST_OUT
  } state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } rc_t;

  function automatic int unsigned pack_idx(input int unsigned r, input int unsigned c);
    return 4 * r + c;
  endfunction

  function automatic rc_t unpack_idx(input int unsigned i);
    rc_t rc;
    rc.row = 2'(i / 4);
    rc.col = 2'(i % 4);
    return rc;
  endfunction

  // Element 0 sits at the MSB end of a packed tile bus.
  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned w);
    return (TILE_N - 1 - i) * w;
  endfunction

endpackage

// File: rtl/winograd_out_transform_if.sv
// Handshake bundle between the product-tile producer, the output transform
// and the downstream consumer of 2x2 output tiles.
interface winograd_out_transform_if
  import winograd_pkg::*;
#(
  parameter int unsigned ELEM_W = winograd_pkg::ELEM_W,
  parameter int unsigned OUT_W  = winograd_pkg::OUT_W,
  parameter int unsigned CNT_W  = winograd_pkg::CNT_W
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [TILE_N*ELEM_W-1:0]   in_m;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_N*OUT_W-1:0]     out_y;
  logic [CNT_W-1:0]           out_cnt;
  logic                       out_ovf;

  modport master (
    output in_valid, in_m, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_m, in_last, out_ready,
    output in_ready, out_valid, out_y, out_cnt, out_ovf
  );

endinterface

// File: rtl/wino_at_row.sv
// One-dimensional A^T transform of a 4-vector: p0 = v0+v1+v2, p1 = v1-v2-v3.
module wino_at_row #(
  parameter int unsigned IN_W  = 25,
  parameter int unsigned OUT_W = 27
) (
  input  logic signed [IN_W-1:0]  v0,
  input  logic signed [IN_W-1:0]  v1,
  input  logic signed [IN_W-1:0]  v2,
  input  logic signed [IN_W-1:0]  v3,
  output logic signed [OUT_W-1:0] p0,
  output logic signed [OUT_W-1:0] p1
);

  logic signed [OUT_W-1:0] e0, e1, e2, e3;

  always_comb begin
    e0 = OUT_W'(v0);
    e1 = OUT_W'(v1);
    e2 = OUT_W'(v2);
    e3 = OUT_W'(v3);
    p0 = e0 + e1 + e2;
    p1 = e1 - e2 - e3;
  end

endmodule

// File: rtl/winograd_out_transform.sv
// Channel accumulator bank and two-stage Y = A^T*Acc*A transform producing
// one signed 2x2 output tile per channel group.
module winograd_out_transform
  import winograd_pkg::*;
#(
  parameter int unsigned ELEM_W = winograd_pkg::ELEM_W,
  parameter int unsigned ACC_W  = winograd_pkg::ACC_W,
  parameter int unsigned OUT_W  = winograd_pkg::OUT_W,
  parameter int unsigned CNT_W  = winograd_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      rstn,
  winograd_out_transform_if.slave   io
);

  // Internal stages carry enough headroom for saturated accumulators;
  // only the low OUT_W bits are presented on out_y.
  localparam int unsigned T_W = ACC_W + 3;
  localparam int unsigned Y_W = ACC_W + 5;

  state_t                  state, state_next;
  logic [ELEM_W-1:0]       m      [TILE_N];
  logic [ACC_W-1:0]        acc    [TILE_N];
  logic [ACC_W:0]          sum_w  [TILE_N];
  logic [ACC_W-1:0]        acc_nx [TILE_N];
  logic signed [ACC_W:0]   a_s    [TILE_N];
  logic                    sat_any;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;
  logic                    accept;
  logic signed [T_W-1:0]   t_d [2][4];
  logic signed [T_W-1:0]   t_q [2][4];
  logic signed [Y_W-1:0]   y_d [2][2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_ACCUM;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    io.in_ready = 1'b0;
    unique case (state)
      ST_ACCUM: begin
        io.in_ready = 1'b1;
        if (io.in_valid && io.in_last) state_next = ST_XF1;
      end
      ST_XF1:  state_next = ST_XF2;
      ST_XF2:  state_next = ST_OUT;
      ST_OUT:  if (io.out_ready) state_next = ST_ACCUM;
      default: state_next = ST_ACCUM;
    endcase
  end

  assign accept = io.in_valid && io.in_ready;

  always_comb begin
    sat_any = 1'b0;
    for (int unsigned i = 0; i < TILE_N; i++) begin
      m[i]      = io.in_m[elem_lsb(i, ELEM_W) +: ELEM_W];
      sum_w[i]  = {1'b0, acc[i]} + (ACC_W + 1)'(m[i]);
      acc_nx[i] = sum_w[i][ACC_W] ? '1 : sum_w[i][ACC_W-1:0];
      sat_any   = sat_any | sum_w[i][ACC_W];
      a_s[i]    = {1'b0, acc[i]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < TILE_N; i++) acc[i] <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      for (int unsigned i = 0; i < TILE_N; i++) acc[i] <= acc_nx[i];
      cnt <= cnt + 1'b1;
      ovf <= ovf | sat_any;
    end else if (state == ST_XF2) begin
      for (int unsigned i = 0; i < TILE_N; i++) acc[i] <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    wino_at_row #(.IN_W(ACC_W + 1), .OUT_W(T_W)) u_col (
      .v0 (a_s[pack_idx(0, c)]),
      .v1 (a_s[pack_idx(1, c)]),
      .v2 (a_s[pack_idx(2, c)]),
      .v3 (a_s[pack_idx(3, c)]),
      .p0 (t_d[0][c]),
      .p1 (t_d[1][c])
    );
  end

  for (genvar r = 0; r < 2; r++) begin : g_row
    wino_at_row #(.IN_W(T_W), .OUT_W(Y_W)) u_row (
      .v0 (t_q[r][0]),
      .v1 (t_q[r][1]),
      .v2 (t_q[r][2]),
      .v3 (t_q[r][3]),
      .p0 (y_d[r][0]),
      .p1 (y_d[r][1])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < 2; r++)
        for (int unsigned c = 0; c < 4; c++) t_q[r][c] <= '0;
      io.out_y     <= '0;
      io.out_cnt   <= '0;
      io.out_ovf   <= 1'b0;
      io.out_valid <= 1'b0;
    end else begin
      if (state == ST_XF1) begin
        for (int unsigned r = 0; r < 2; r++)
          for (int unsigned c = 0; c < 4; c++) t_q[r][c] <= t_d[r][c];
      end
      if (state == ST_XF2) begin
        for (int unsigned r = 0; r < 2; r++)
          for (int unsigned c = 0; c < 2; c++)
            io.out_y[(OUT_N - 1 - (2 * r + c)) * OUT_W +: OUT_W] <= y_d[r][c][OUT_W-1:0];
        io.out_cnt   <= cnt;
        io.out_ovf   <= ovf;
        io.out_valid <= 1'b1;
      end else if (state == ST_OUT && io.out_ready) begin
        io.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_winograd_out_transform.sv
// Directed and randomized checks of the Winograd output transform against a
// matrix-level reference model (saturating channel sums, then A^T*Acc*A).
module tb_winograd_out_transform;
  import winograd_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  winograd_out_transform_if #(.ELEM_W(ELEM_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  winograd_out_transform #(
    .ELEM_W(ELEM_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus.slave)
  );

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  int unsigned tile [16];
  longint      ref_acc [16];
  int unsigned ref_cnt;
  bit          ref_ovf;
  int          at_mat [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
  longint      acc_max = (longint'(1) << ACC_W) - 1;

  logic [4*OUT_W-1:0] gy;
  logic [CNT_W-1:0]   gc;
  logic               go;
  int unsigned        waited;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*OUT_W-1:0] pack_y(input int y00, input int y01, input int y10, input int y11);
    logic [4*OUT_W-1:0] v;
    v[3*OUT_W +: OUT_W] = y00[OUT_W-1:0];
    v[2*OUT_W +: OUT_W] = y01[OUT_W-1:0];
    v[1*OUT_W +: OUT_W] = y10[OUT_W-1:0];
    v[0*OUT_W +: OUT_W] = y11[OUT_W-1:0];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_acc[i] = 0;
    ref_cnt = 0;
    ref_ovf = 1'b0;
  endtask

  task automatic model_accept();
    for (int i = 0; i < 16; i++) begin
      ref_acc[i] += longint'(tile[i]);
      if (ref_acc[i] > acc_max) begin
        ref_acc[i] = acc_max;
        ref_ovf    = 1'b1;
      end
    end
    ref_cnt++;
  endtask

  function automatic logic [4*OUT_W-1:0] model_y();
    longint tm [2][4];
    longint y  [2][2];
    logic [4*OUT_W-1:0] v;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        tm[r][c] = 0;
        for (int k = 0; k < 4; k++) tm[r][c] += at_mat[r][k] * ref_acc[4*k + c];
      end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        y[r][c] = 0;
        for (int k = 0; k < 4; k++) y[r][c] += tm[r][k] * at_mat[c][k];
        v[(3 - (2*r + c))*OUT_W +: OUT_W] = y[r][c][OUT_W-1:0];
      end
    return v;
  endfunction

  task automatic fill_all(input int unsigned v);
    for (int i = 0; i < 16; i++) tile[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) tile[i] = $urandom_range(0, 65535);
  endtask

  task automatic drive_bus(input bit last);
    for (int i = 0; i < 16; i++) bus.in_m[(15 - i)*ELEM_W +: ELEM_W] = tile[i][ELEM_W-1:0];
    bus.in_last  = last;
    bus.in_valid = 1'b1;
  endtask

  task automatic send(input bit last, output int unsigned w);
    w = 0;
    @(negedge clk);
    drive_bus(last);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", bus.in_ready, 1);
    end else begin
      @(posedge clk);
      model_accept();
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic recv(input bit chk_lat, input int unsigned hold, input bit preload,
                      output logic [4*OUT_W-1:0] y, output logic [CNT_W-1:0] c, output logic o);
    logic [4*OUT_W-1:0] ey;
    logic [CNT_W-1:0]   ec;
    logic               eo;
    int unsigned        n;
    ey = model_y();
    ec = ref_cnt[CNT_W-1:0];
    eo = ref_ovf;
    model_clear();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 100);
    y = bus.out_y;
    c = bus.out_cnt;
    o = bus.out_ovf;
    check("out_valid", bus.out_valid, 1);
    if (chk_lat) check("latency", n, 3);
    check("out_y", y, ey);
    check("out_cnt", c, ec);
    check("out_ovf", o, eo);
    check("in_ready_busy", bus.in_ready, 0);
    if (preload) begin
      fill_all(1);
      drive_bus(1'b1);
    end
    for (int unsigned k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_y", bus.out_y, ey);
      check("hold_cnt", bus.out_cnt, ec);
      check("hold_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", bus.out_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    #2;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_y", bus.out_y, 0);
    check("rst_out_cnt", bus.out_cnt, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_m      = '0;
    bus.out_ready = 1'b0;
    model_clear();
    pulse_reset();

    // Single all-ones tile
    fill_all(1);
    send(1'b1, waited);
    recv(1'b1, 0, 1'b0, gy, gc, go);
    check("t1_y", gy, pack_y(9, -3, -3, 1));
    check("t1_cnt", gc, 1);

    // Only m(1,1) = 5
    fill_all(0);
    tile[pack_idx(1, 1)] = 5;
    send(1'b1, waited);
    recv(1'b1, 0, 1'b0, gy, gc, go);
    check("t2_y", gy, pack_y(5, 5, 5, 5));

    // Three back-to-back all-ones tiles
    fill_all(1);
    for (int k = 0; k < 3; k++) begin
      send(k == 2, waited);
      check("t3_b2b_ready", waited, 0);
    end
    recv(1'b1, 0, 1'b0, gy, gc, go);
    check("t3_y", gy, pack_y(27, -9, -9, 3));
    check("t3_cnt", gc, 3);

    // Backpressure with an input tile held pending the whole time
    fill_rand();
    send(1'b0, waited);
    fill_rand();
    send(1'b1, waited);
    recv(1'b1, 5, 1'b1, gy, gc, go);
    @(posedge clk);
    model_accept();
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    recv(1'b1, 0, 1'b0, gy, gc, go);
    check("t4_next_y", gy, pack_y(9, -3, -3, 1));
    check("t4_next_cnt", gc, 1);

    // Saturation over 300 channels
    fill_all(0);
    tile[0] = 16'hFFFF;
    for (int k = 0; k < 300; k++) send(k == 299, waited);
    recv(1'b1, 0, 1'b0, gy, gc, go);
    check("t5_y", gy, pack_y(16777215, 0, 0, 0));
    check("t5_ovf", go, 1);
    check("t5_cnt", gc, 44);
    fill_all(2);
    send(1'b1, waited);
    recv(1'b1, 0, 1'b0, gy, gc, go);
    check("t5_next_ovf", go, 0);

    // Reset in the middle of a group
    fill_rand();
    send(1'b0, waited);
    fill_rand();
    send(1'b0, waited);
    pulse_reset();
    fill_all(1);
    send(1'b1, waited);
    recv(1'b1, 0, 1'b0, gy, gc, go);
    check("t6_y", gy, pack_y(9, -3, -3, 1));
    check("t6_cnt", gc, 1);

    // Randomized groups with input bubbles and output backpressure
    for (int g = 0; g < 25; g++) begin
      int unsigned ntiles;
      ntiles = $urandom_range(1, 8);
      for (int unsigned k = 0; k < ntiles; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        fill_rand();
        send(k == ntiles - 1, waited);
      end
      recv(1'b1, $urandom_range(0, 3), 1'b0, gy, gc, go);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
